// File: rtl/axi_stream_packer.sv
// rtl/axi_stream_packer.sv - packs a sparse-tkeep byte stream into full beats
// A 2*BW byte buffer absorbs one input beat while the low BW bytes are offered downstream.
module axi_stream_packer #(
    parameter int BW = 4
) (
    input  logic              clk,
    input  logic              rst,
    output logic              s_tready,
    input  logic              s_tvalid,
    input  logic [8*BW-1:0]   s_tdata,
    input  logic [BW-1:0]     s_tkeep,
    input  logic              s_tlast,
    input  logic              m_tready,
    output logic              m_tvalid,
    output logic [8*BW-1:0]   m_tdata,
    output logic [BW-1:0]     m_tkeep,
    output logic              m_tlast,
    output logic [15:0]       pkt_cnt
);
    localparam int CW = $clog2(2*BW+1);
    localparam logic [CW-1:0] BW_C = CW'(BW);

    logic [16*BW-1:0] buf_q, buf_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic             last_pending_q, last_pending_d;
    logic [15:0]      pkt_cnt_q, pkt_cnt_d;
    logic             out_fire, in_fire;
    int               pos;

    assign m_tvalid = (cnt_q >= BW_C) || (last_pending_q && (cnt_q != '0));
    assign m_tlast  = last_pending_q && (cnt_q <= BW_C);
    assign s_tready = !last_pending_q && ((cnt_q < BW_C) || m_tready);
    assign pkt_cnt  = pkt_cnt_q;
    assign out_fire = m_tvalid && m_tready;
    assign in_fire  = s_tvalid && s_tready;

    always_comb begin
        m_tkeep = '0;
        m_tdata = '0;
        for (int i = 0; i < BW; i++) begin
            m_tkeep[i] = CW'(i) < cnt_q;
            m_tdata[8*i +: 8] = m_tkeep[i] ? buf_q[8*i +: 8] : 8'h00;
        end
    end

    always_comb begin
        buf_d          = buf_q;
        cnt_d          = cnt_q;
        last_pending_d = last_pending_q;
        pkt_cnt_d      = pkt_cnt_q;
        if (out_fire) begin
            if (m_tlast) begin
                buf_d          = '0;
                cnt_d          = '0;
                last_pending_d = 1'b0;
                pkt_cnt_d      = pkt_cnt_q + 16'd1;
            end else begin
                buf_d = buf_q >> (8*BW);
                cnt_d = cnt_q - BW_C;
            end
        end else if (last_pending_q && (cnt_q == '0)) begin
            // empty packet: nothing to emit, so the terminator is simply dropped
            last_pending_d = 1'b0;
        end
        pos = int'(cnt_d);
        if (in_fire) begin
            for (int i = 0; i < BW; i++) begin
                if (s_tkeep[i]) begin
                    if (pos < 2*BW) begin
                        buf_d[8*pos +: 8] = s_tdata[8*i +: 8];
                    end
                    pos = pos + 1;
                end
            end
            cnt_d = CW'(pos);
            if (s_tlast) begin
                last_pending_d = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            buf_q          <= '0;
            cnt_q          <= '0;
            last_pending_q <= 1'b0;
            pkt_cnt_q      <= '0;
        end else begin
            buf_q          <= buf_d;
            cnt_q          <= cnt_d;
            last_pending_q <= last_pending_d;
            pkt_cnt_q      <= pkt_cnt_d;
        end
    end
endmodule

// File: tb/tb_axi_stream_packer.sv
// tb/tb_axi_stream_packer.sv - scoreboard bench for axi_stream_packer
module tb_axi_stream_packer;
    localparam int BW = 4;

    typedef struct {
        logic [8*BW-1:0] d;
        logic [BW-1:0]   k;
        logic            l;
    } beat_t;

    logic            clk, rst;
    logic            s_tready, s_tvalid, s_tlast;
    logic [8*BW-1:0] s_tdata;
    logic [BW-1:0]   s_tkeep;
    logic            m_tready, m_tvalid, m_tlast;
    logic [8*BW-1:0] m_tdata;
    logic [BW-1:0]   m_tkeep;
    logic [15:0]     pkt_cnt;

    logic            rr_en, rr_q, mt_fix;
    assign m_tready = rr_en ? rr_q : mt_fix;

    beat_t       exp_q[$];
    logic [7:0]  pend[$];
    logic [15:0] exp_pkts;
    int          checks, failures;

    axi_stream_packer #(.BW(BW)) dut (
        .clk(clk), .rst(rst),
        .s_tready(s_tready), .s_tvalid(s_tvalid), .s_tdata(s_tdata),
        .s_tkeep(s_tkeep), .s_tlast(s_tlast),
        .m_tready(m_tready), .m_tvalid(m_tvalid), .m_tdata(m_tdata),
        .m_tkeep(m_tkeep), .m_tlast(m_tlast), .pkt_cnt(pkt_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        rr_q = ($urandom_range(0, 3) != 0);
    end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
        end
    endtask

    // Reference: a packet is a byte list; full chunks leave as soon as they exist
    // unless they are the final chunk of a packet whose end is already known.
    function automatic void emit(int n, bit l);
        beat_t b;
        b.d = '0;
        b.k = '0;
        b.l = l;
        for (int i = 0; i < n; i++) begin
            b.d[8*i +: 8] = pend.pop_front();
            b.k[i] = 1'b1;
        end
        exp_q.push_back(b);
        if (l) exp_pkts = exp_pkts + 16'd1;
    endfunction

    function automatic void model_accept(logic [BW-1:0] k, logic [8*BW-1:0] d, logic l);
        for (int i = 0; i < BW; i++)
            if (k[i]) pend.push_back(d[8*i +: 8]);
        while (pend.size() > BW || (pend.size() == BW && !l)) emit(BW, 1'b0);
        if (l && pend.size() > 0) emit(pend.size(), 1'b1);
    endfunction

    function automatic void model_reset();
        exp_q.delete();
        pend.delete();
        exp_pkts = '0;
    endfunction

    logic            prev_stall;
    logic [8*BW-1:0] pd;
    logic [BW-1:0]   pk;
    logic            pl;

    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                chk("stall_valid", {63'd0, m_tvalid}, 64'd1);
                chk("stall_data", {32'd0, m_tdata, m_tkeep, 3'd0, m_tlast}, {32'd0, pd, pk, 3'd0, pl});
            end
            if (m_tvalid && m_tready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_beat", {32'd0, m_tdata}, 64'd0 - 64'd1);
                end else begin
                    beat_t e;
                    e = exp_q.pop_front();
                    chk("beat_data", {32'd0, m_tdata}, {32'd0, e.d});
                    chk("beat_keep", {60'd0, m_tkeep}, {60'd0, e.k});
                    chk("beat_last", {63'd0, m_tlast}, {63'd0, e.l});
                end
            end
            prev_stall = m_tvalid && !m_tready;
            pd = m_tdata;
            pk = m_tkeep;
            pl = m_tlast;
        end
    end

    task automatic send(input logic [BW-1:0] k, input logic [8*BW-1:0] d, input logic l);
        int  n;
        bit  done;
        n    = 0;
        done = 1'b0;
        s_tvalid = 1'b1; s_tkeep = k; s_tdata = d; s_tlast = l;
        while (!done) begin
            @(negedge clk);
            if (s_tready) begin
                model_accept(k, d, l);
                done = 1'b1;
            end else if (++n > 100) begin
                checks++;
                failures++;
                $display("FAIL send_timeout: got s_tready=0 for %0d cycles expected 1", n);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        s_tvalid = 1'b0; s_tkeep = '0; s_tdata = '0; s_tlast = 1'b0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (exp_q.size() != 0) begin
            checks++;
            failures++;
            $display("FAIL drain_timeout: got %0d beats outstanding expected 0", exp_q.size());
            exp_q.delete();
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        checks = 0; failures = 0;
        model_reset();
        rst = 1'b1; rr_en = 1'b0; mt_fix = 1'b1;
        s_tvalid = 1'b0; s_tkeep = '0; s_tdata = '0; s_tlast = 1'b0;
        prev_stall = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst_m_tvalid", {63'd0, m_tvalid}, 64'd0);
        chk("rst_m_tkeep", {60'd0, m_tkeep}, 64'd0);
        chk("rst_m_tlast", {63'd0, m_tlast}, 64'd0);
        chk("rst_m_tdata", {32'd0, m_tdata}, 64'd0);
        chk("rst_s_tready", {63'd0, s_tready}, 64'd1);
        chk("rst_pkt_cnt", {48'd0, pkt_cnt}, 64'd0);
        @(posedge clk); #1;

        send(4'b1111, 32'h44332211, 1'b1);
        chk("t1_latency_valid", {63'd0, m_tvalid}, 64'd1);
        chk("t1_latency_last", {63'd0, m_tlast}, 64'd1);
        drain();
        chk("t1_pkt_cnt", {48'd0, pkt_cnt}, {48'd0, exp_pkts});

        send(4'b0101, 32'hDDCCBBAA, 1'b0);
        send(4'b1010, 32'h44332211, 1'b1);
        drain();
        chk("t2_pkt_cnt", {48'd0, pkt_cnt}, {48'd0, exp_pkts});

        send(4'b0111, 32'h00635241, 1'b0);
        send(4'b0111, 32'h00A4B3C2, 1'b0);
        send(4'b0001, 32'h000000E5, 1'b1);
        drain();

        send(4'b0000, 32'h0, 1'b1);
        chk("t4_s_tready_low", {63'd0, s_tready}, 64'd0);
        chk("t4_no_valid", {63'd0, m_tvalid}, 64'd0);
        @(posedge clk); #1;
        chk("t4_s_tready_back", {63'd0, s_tready}, 64'd1);
        chk("t4_no_valid2", {63'd0, m_tvalid}, 64'd0);
        chk("t4_pkt_cnt", {48'd0, pkt_cnt}, {48'd0, exp_pkts});

        mt_fix = 1'b0;
        send(4'b0111, 32'h00332211, 1'b0);
        send(4'b1111, 32'h77665544, 1'b1);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            chk("t5_s_tready", {63'd0, s_tready}, 64'd0);
            chk("t5_valid", {63'd0, m_tvalid}, 64'd1);
        end
        mt_fix = 1'b1;
        @(negedge clk);
        chk("t5_first_valid", {63'd0, m_tvalid}, 64'd1);
        chk("t5_first_last", {63'd0, m_tlast}, 64'd0);
        @(negedge clk);
        chk("t5_second_valid", {63'd0, m_tvalid}, 64'd1);
        chk("t5_second_last", {63'd0, m_tlast}, 64'd1);
        @(posedge clk); #1;
        drain();
        chk("t5_pkt_cnt", {48'd0, pkt_cnt}, {48'd0, exp_pkts});

        for (int j = 0; j < 8; j++) begin
            send(4'b1111, $urandom, 1'b0);
            if (j == 0) chk("t6_latency", {63'd0, m_tvalid}, 64'd1);
        end
        mt_fix = 1'b0;
        #2 rst = 1'b1;
        #1 chk("t6_async_rst", {63'd0, m_tvalid}, 64'd0);
        model_reset();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        mt_fix = 1'b1;
        repeat (10) @(posedge clk);
        #1;
        chk("t6_post_rst_valid", {63'd0, m_tvalid}, 64'd0);
        chk("t6_post_rst_pkt", {48'd0, pkt_cnt}, 64'd0);

        rr_en = 1'b1;
        for (int j = 0; j < 400; j++) begin
            send(BW'($urandom), $urandom, ($urandom_range(0, 4) == 0));
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end
        end
        send(4'b0000, 32'h0, 1'b1);
        rr_en  = 1'b0;
        mt_fix = 1'b1;
        drain();
        chk("rand_pkt_cnt", {48'd0, pkt_cnt}, {48'd0, exp_pkts});
        chk("rand_residue", 64'(pend.size()), 64'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
